// File: rtl/mul_div_unit.sv
// Iterative MIPS multiply/divide unit with HI/LO; WIDTH+1 busy cycles per MULT/DIV, single-cycle MTHI/MTLO.
// Optional MADD/MADDU accumulate path is enabled by defining MUL_DIV_MADD_EN.
module mul_div_unit #(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   acc_hi_q, acc_lo_q, opnd_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               is_div_q, neg_q, rem_neg_q, div0_q, done_q;

  logic               accept, is_mt, is_mc, is_div_op, sgn_op, a_neg, b_neg, last_iter;
  logic [WIDTH-1:0]   a_mag, b_mag;

  assign accept    = start && (state_q == S_IDLE);
  assign is_mt     = (op[2:1] == 2'b10);
  assign is_div_op = (op[2:1] == 2'b01);
  assign sgn_op    = ~op[0];
  assign a_neg     = sgn_op & A[WIDTH-1];
  assign b_neg     = sgn_op & B[WIDTH-1];
  assign a_mag     = a_neg ? (WIDTH'(0) - A) : A;
  assign b_mag     = b_neg ? (WIDTH'(0) - B) : B;
  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

`ifdef MUL_DIV_MADD_EN
  logic madd_q;
  assign is_mc = ~is_mt;
`else
  assign is_mc = ~op[2];
`endif

  // Multiply step: acc_lo holds the remaining multiplier bits, product shifts in from the top.
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   mul_hi_n, mul_lo_n;
  assign mul_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
  assign mul_hi_n = mul_sum[WIDTH:1];
  assign mul_lo_n = {mul_sum[0], acc_lo_q[WIDTH-1:1]};

  // Restoring divide step: acc_hi is the partial remainder, acc_lo shifts dividend out and quotient in.
  logic [WIDTH:0]     div_sh;
  logic               div_ge;
  logic [WIDTH-1:0]   div_hi_n, div_lo_n;
  assign div_sh   = {acc_hi_q, acc_lo_q[WIDTH-1]};
  assign div_ge   = (div_sh >= {1'b0, opnd_q});
  assign div_hi_n = div_ge ? (div_sh[WIDTH-1:0] - opnd_q) : div_sh[WIDTH-1:0];
  assign div_lo_n = {acc_lo_q[WIDTH-2:0], div_ge};

  logic [2*WIDTH-1:0] prod, prod_fix, res;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  assign prod     = {acc_hi_q, acc_lo_q};
  assign prod_fix = neg_q ? ((2*WIDTH)'(0) - prod) : prod;
  assign quo_fix  = div0_q ? {WIDTH{1'b1}} : (neg_q ? (WIDTH'(0) - acc_lo_q) : acc_lo_q);
  assign rem_fix  = rem_neg_q ? (WIDTH'(0) - acc_hi_q) : acc_hi_q;

`ifdef MUL_DIV_MADD_EN
  logic [2*WIDTH-1:0] hl_sum;
  assign hl_sum = {hi_q, lo_q} + prod_fix;
  assign res    = is_div_q ? {rem_fix, quo_fix} : (madd_q ? hl_sum : prod_fix);
`else
  assign res    = is_div_q ? {rem_fix, quo_fix} : prod_fix;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept && is_mc) state_d = S_RUN;
      S_RUN:   if (last_iter)       state_d = S_FIX;
      S_FIX:                        state_d = S_IDLE;
      default:                      state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      opnd_q    <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      div0_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
`ifdef MUL_DIV_MADD_EN
      madd_q    <= 1'b0;
`endif
    end else begin
      done_q <= (state_q == S_FIX);
      case (state_q)
        S_IDLE: if (accept) begin
          if (is_mt) begin
            if (op[0]) lo_q <= A;
            else       hi_q <= A;
          end else if (is_mc) begin
            cnt_q     <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= is_div_op ? a_mag : b_mag;
            opnd_q    <= is_div_op ? b_mag : a_mag;
            is_div_q  <= is_div_op;
            neg_q     <= a_neg ^ b_neg;
            rem_neg_q <= a_neg;
            div0_q    <= is_div_op && (B == '0);
`ifdef MUL_DIV_MADD_EN
            madd_q    <= op[2];
`endif
          end
        end
        S_RUN: begin
          cnt_q    <= cnt_q + 1'b1;
          acc_hi_q <= is_div_q ? div_hi_n : mul_hi_n;
          acc_lo_q <= is_div_q ? div_lo_n : mul_lo_n;
        end
        S_FIX: {hi_q, lo_q} <= res;
        default: ;
      endcase
    end
  end

  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Parametrised, iterative multiply/divide unit with architectural HI/LO registers for the pipeline EX stage.
- Sits beside the single-cycle ALU.
- Performs MIPS MULT/MULTU/DIV/DIVU in WIDTH+1 cycles, plus single-cycle MTHI/MTLO writes.
- Asserts busy so the hazard unit stalls MFHI/MFLO and further MDU ops until the result lands.

Parameters:
WIDTH, 32, operand/HI/LO width in bits (>=4).
CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; not overridden).

Ports:
clk  input  1  clock, rising edge.
rst  input  1  synchronous reset, active-high.
start  input  1  request; sampled only when busy=0.
op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110 MADD, 111 MADDU.
A  input  WIDTH  rs operand (multiplicand / dividend / MTHI-MTLO data).
B  input  WIDTH  rt operand (multiplier / divisor).
busy  output  1  operation in progress.
done  output  1  one-cycle pulse: HI/LO just updated by a multi-cycle op.
hi  output  WIDTH  HI register.
lo  output  WIDTH  LO register.

Behaviour:
- Reset: synchronous, active-high. All of the following happen on the clk edge with rst=1, overriding any in-flight op: state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0; operands/partial results discarded.
- FSM states IDLE, RUN, FIX; busy = (state != IDLE).
- IDLE, start=1, op=MTHI/MTLO: hi (resp. lo) <= A at that edge; stay IDLE; no busy, no done.
- IDLE, start=1, multi-cycle op: latch |A|,|B| (signed ops) or A,B (unsigned) and the sign flags; counter<=0; ->RUN.
- RUN: one iteration per cycle; counter increments; after WIDTH iterations ->FIX.
  - Multiply: shift-add, 2*WIDTH-bit product.
  - Divide: restoring, one quotient bit per cycle.
- FIX: apply sign correction.
  - MULT: negate product if sign(A)^sign(B).
  - DIV: negate quotient if sign(A)^sign(B); remainder takes sign of A.
  - Write {hi,lo}: mult -> hi=product[2W-1:W], lo=product[W-1:0]; div -> hi=remainder, lo=quotient.
  - ->IDLE; done<=1 for exactly one cycle.
- Latency: start accepted at edge 0; busy=1 for cycles after edges 0..WIDTH (WIDTH+1 cycles); hi/lo updated at edge WIDTH+1; done=1 in the following cycle with busy=0.
- Back-to-back: a new start is accepted in the done cycle.
- start while busy: ignored, no effect; the pipeline must stall on busy.
- Divide by zero (B=0, DIV or DIVU): no trap; hi=A (raw dividend), lo=all ones; same latency.
- Signed overflow, DIV of most-negative by -1: lo=most-negative, hi=0 (falls out of the magnitude algorithm; required).
- MULT of most-negative by most-negative: exact positive product 2^(2W-2).
- hi/lo hold their value at all times except at MTHI/MTLO and FIX edges.

Optional Feature:
- Macro MUL_DIV_MADD_EN.
- Defined: op 110 (MADD, signed) and 111 (MADDU, unsigned) run the multiply path. At FIX, {hi,lo} <= {hi,lo} + product (signed product sign-extended), wrapping mod 2^(2*WIDTH). Same latency and done pulse.
- Undefined: op 110/111 with start=1 are ignored exactly like start=0 (no busy, hi/lo unchanged). No accumulate adder is synthesised.

Test Plan:
- Reset then MTHI A=0x12345678, then MTLO A=0x9ABCDEF0 -> hi=0x12345678, lo=0x9ABCDEF0 one edge after each; busy and done stay 0.
- MULT A=0xFFFFFFFE(-2), B=0x00000003 -> busy for 33 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA, done pulse of 1 cycle. MULTU of the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV A=0xFFFFFFF9(-7), B=0x00000002 -> lo=0xFFFFFFFD(-3), hi=0xFFFFFFFF(-1). DIVU A=7, B=0 -> hi=7, lo=0xFFFFFFFF. DIV 0x80000000 by 0xFFFFFFFF -> lo=0x80000000, hi=0.
- start pulsed with MULTU A=5, B=5 during cycle 10 of a DIVU 100/7 -> ignored; result hi=2, lo=14. Then a new MULTU 5*5 is issued in the done cycle -> hi=0, lo=25 at 33 cycles later.
- rst asserted during cycle 15 of a MULT -> next cycle busy=0, done=0, hi=lo=0, and no result is written afterwards.
- With MUL_DIV_MADD_EN: hi=0, lo=0xFFFFFFFF, then MADDU A=1, B=1 -> hi=1, lo=0. Without the macro, the same op leaves hi/lo unchanged and busy=0.
